// File: rtl/lt_pattern_driver.sv
// lt_pattern_driver: byte-command pattern source for the level-translator
// board (8 chip enables, 64 data pins). Commands arrive over valid/ready:
//   01 en        SET_EN
//   02 lane val  SET_BYTE (lane > 7 is consumed but ignored)
//   03 mode      MODE (0 static, 1 walk-one, 2 walk-zero, 3 count)
//   04           CLEAR
// Auto modes step data once every STEP_DIV clocks.
// Build macro LT_SAFE_EN: an enable change blanks enable_bit for GUARD_CYC
// cycles (break-before-make) before the new value is driven.
//
// state   | meaning
// S_IDLE  | waiting for an opcode byte
// S_ARG1  | waiting for first argument
// S_ARG2  | waiting for second argument (SET_BYTE only)
// S_APPLY | one-cycle command execution, cmd_ready low
// S_GUARD | enable blanking window (LT_SAFE_EN builds only)
module lt_pattern_driver #(
    parameter int unsigned STEP_DIV  = 25000000,
    parameter int unsigned DIV_W     = 26,
    parameter int unsigned GUARD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  enable_bit,
    output logic [63:0] data_bit,
    output logic [1:0]  mode
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARG1  = 3'd1,
        S_ARG2  = 3'd2,
        S_APPLY = 3'd3,
        S_GUARD = 3'd4
    } state_t;

    localparam logic [7:0] OP_SET_EN   = 8'h01;
    localparam logic [7:0] OP_SET_BYTE = 8'h02;
    localparam logic [7:0] OP_MODE     = 8'h03;
    localparam logic [7:0] OP_CLEAR    = 8'h04;

    state_t             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [7:0]         arg1_q, arg1_d;
    logic [7:0]         arg2_q, arg2_d;
    logic               rdy_q, rdy_d;
    logic [7:0]         en_q, en_d;
    logic [63:0]        data_q, data_d;
    logic [1:0]         mode_q, mode_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               hs;
    logic               tick;

`ifdef LT_SAFE_EN
    localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    logic [7:0]         en_pend_q, en_pend_d;
    logic [GW-1:0]      guard_q, guard_d;
`endif

    assign hs   = cmd_valid && rdy_q;
    assign tick = (mode_q != 2'd0) && (div_q == DIV_W'(STEP_DIV - 1));

    // Next-state logic: parser, prescaler and pattern stepping; a command
    // executing in APPLY overrides a coincident tick.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg1_d  = arg1_q;
        arg2_d  = arg2_q;
        rdy_d   = rdy_q;
        en_d    = en_q;
        data_d  = data_q;
        mode_d  = mode_q;
`ifdef LT_SAFE_EN
        en_pend_d = en_pend_q;
        guard_d   = guard_q;
`endif

        if (mode_q == 2'd0 || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (tick) begin
            if (mode_q == 2'd3) begin
                data_d = data_q + 64'd1;
            end else begin
                data_d = {data_q[62:0], data_q[63]};
            end
        end

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    op_d = cmd_data;
                    case (cmd_data)
                        OP_SET_EN, OP_SET_BYTE, OP_MODE: state_d = S_ARG1;
                        OP_CLEAR: begin
                            state_d = S_APPLY;
                            rdy_d   = 1'b0;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_ARG1: begin
                if (hs) begin
                    arg1_d = cmd_data;
                    if (op_q == OP_SET_BYTE) begin
                        state_d = S_ARG2;
                    end else begin
                        state_d = S_APPLY;
                        rdy_d   = 1'b0;
                    end
                end
            end
            S_ARG2: begin
                if (hs) begin
                    arg2_d  = cmd_data;
                    state_d = S_APPLY;
                    rdy_d   = 1'b0;
                end
            end
            S_APPLY: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
                data_d  = data_q;
                case (op_q)
                    OP_SET_EN: begin
`ifdef LT_SAFE_EN
                        if (arg1_q != en_q) begin
                            en_d      = 8'h00;
                            en_pend_d = arg1_q;
                            guard_d   = GW'(GUARD_CYC - 1);
                            state_d   = S_GUARD;
                            rdy_d     = 1'b0;
                        end
`else
                        en_d = arg1_q;
`endif
                    end
                    OP_SET_BYTE: begin
                        if (arg1_q < 8'd8) begin
                            data_d[{arg1_q[2:0], 3'b000} +: 8] = arg2_q;
                        end
                    end
                    OP_MODE: begin
                        mode_d = arg1_q[1:0];
                        div_d  = '0;
                        if (arg1_q[1:0] == 2'd1) begin
                            data_d = 64'h1;
                        end else if (arg1_q[1:0] == 2'd2) begin
                            data_d = ~64'h1;
                        end
                    end
                    OP_CLEAR: begin
                        data_d = '0;
                        en_d   = 8'h00;
                        mode_d = 2'd0;
                        div_d  = '0;
                    end
                    default: ;
                endcase
            end
`ifdef LT_SAFE_EN
            S_GUARD: begin
                if (guard_q == '0) begin
                    en_d    = en_pend_q;
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                end else begin
                    guard_d = guard_q - GW'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 8'h00;
            arg1_q  <= 8'h00;
            arg2_q  <= 8'h00;
            rdy_q   <= 1'b1;
            en_q    <= 8'h00;
            data_q  <= '0;
            mode_q  <= 2'd0;
            div_q   <= '0;
`ifdef LT_SAFE_EN
            en_pend_q <= 8'h00;
            guard_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg1_q  <= arg1_d;
            arg2_q  <= arg2_d;
            rdy_q   <= rdy_d;
            en_q    <= en_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
`ifdef LT_SAFE_EN
            en_pend_q <= en_pend_d;
            guard_q   <= guard_d;
`endif
        end
    end

    assign cmd_ready  = rdy_q;
    assign enable_bit = en_q;
    assign data_bit   = data_q;
    assign mode       = mode_q;

endmodule

// File: doc/lt_pattern_driver.md
Name: lt_pattern_driver

Overview:
- Command-driven pattern source for the level-translator board's 8 chip enables and 64 data pins; sits directly upstream of the top-level enable_bit/data_bit outputs.
- Consumes a byte stream, e.g. from the AVR serial/SPI receive path, over a valid/ready handshake.
- Holds static enable/data registers and can auto-step data in walk-one, walk-zero or binary-count modes at a programmable rate, so translator channels can be exercised without host traffic.

Parameters:
- STEP_DIV, 25000000, clk cycles per auto-step tick (0.5 s at 50 MHz); must be >= 2.
- DIV_W, 26, prescaler counter width; must hold STEP_DIV-1.
- GUARD_CYC, 4, break-before-make length in cycles (used only with LT_SAFE_EN).

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous, active-high reset.
- cmd_data  input  8  command/argument byte.
- cmd_valid  input  1  cmd_data valid.
- cmd_ready  output  1  byte accepted on a clock edge where cmd_valid && cmd_ready.
- enable_bit  output  8  chip-enable outputs, registered.
- data_bit  output  64  data outputs, registered.
- mode  output  2  current mode: 0 static, 1 walk-one, 2 walk-zero, 3 count.

Behaviour:
- Clocking and reset: single clock domain (clk). Reset is synchronous and active-high on rst, and dominates all other inputs.
- Reset values:
  - enable_bit = 8'h00, data_bit = 64'h0, mode = 0.
  - cmd_ready = 1, parser in IDLE, prescaler = 0.
- Parser states: IDLE, ARG1, ARG2, APPLY. A byte is consumed only on a handshake edge.
- IDLE: latch the opcode.
  - 0x01 SET_EN, 0x02 SET_BYTE, 0x03 MODE -> ARG1.
  - 0x04 CLEAR -> APPLY.
  - Any other opcode is dropped and the parser stays in IDLE.
- ARG1: latch arg1.
  - SET_BYTE -> ARG2.
  - Others -> APPLY.
- ARG2: latch arg2 -> APPLY.
- APPLY: lasts exactly one cycle with cmd_ready = 0, then returns to IDLE with cmd_ready = 1.
  - The final byte is accepted at edge N. Registers and outputs update at edge N+1. cmd_ready is low between N and N+1.
- Command effects:
  - SET_EN: enable_bit = arg1.
  - SET_BYTE: arg1 is the lane index, arg2 the value; data_bit[8*i+7:8*i] = arg2. If index > 7, no write, but the command is still consumed normally.
  - MODE: mode = arg1[1:0]; arg1[7:2] is ignored. The prescaler is cleared. Entering walk-one loads data 64'h1; walk-zero loads ~64'h1; count and static keep the current data.
  - CLEAR: data 0, enable 0, mode 0, prescaler cleared.
- Prescaler:
  - In static mode the prescaler holds at 0.
  - In auto modes it counts 0..STEP_DIV-1, and a tick is asserted when count == STEP_DIV-1, after which it wraps to 0.
- Tick effects:
  - walk-one / walk-zero: rotate data left by 1; bit63 moves to bit0.
  - count: data = data + 1, mod 2^64; all-ones wraps to 0.
- Simultaneous events:
  - If APPLY and a tick coincide, the command wins and the tick is discarded.
  - A SET_BYTE in an auto mode modifies the live pattern; stepping continues from the modified value.
- Reset mid-command: partial bytes are discarded and the parser returns to IDLE; no register is modified.

Optional Feature:
- Macro: LT_SAFE_EN.
- Defined: break-before-make on enables.
  - Any APPLY that changes the enable value forces enable_bit = 8'h00 for GUARD_CYC cycles starting at edge N+1.
  - The new value appears at edge N+1+GUARD_CYC.
  - cmd_ready stays low until the guard ends.
  - Data updates at N+1 as normal.
  - A CLEAR also drives enables 0 with no extra guard.
- Not defined: enables update at N+1, no guard, and the GUARD_CYC parameter is unused.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream -> enable_bit 00, data_bit 0, mode 0, cmd_ready 1; the next valid command parses from IDLE.
- Basic writes: send 01 A5, then 02 03 3C -> enable_bit A5 one cycle after the final byte; data_bit = 64'h0000_0000_3C00_0000; cmd_ready low exactly one cycle after each command.
- Invalid cases: send 02 09 FF -> data unchanged. Send 7E -> dropped, parser stays in IDLE; a following 01 0F sets enable to 0F.
- Walk-one (STEP_DIV=4): send 03 01 -> data 1, then 2, 4, ... every 4 cycles; after 64 ticks data returns to 1 (the bit63 -> bit0 wrap is checked).
- Count wrap: set all lanes to FF, then 03 03 -> the first tick gives data 0. A CLEAR issued on a tick cycle wins, giving data 0, mode 0.
- With LT_SAFE_EN (GUARD_CYC=4): send 01 FF -> enable_bit 00 for 4 cycles, then FF; cmd_ready low for 5 cycles. Sending 01 with the same value -> no guard.
